// File: rtl/alu_writeback.sv
// alu_writeback: ALU result writeback into a 16x16 register file, with flags and a
// second write cycle that puts the hi/remainder result of ops 4/5 into HI_REG.
// Latency: out1 is written at the accept edge; out2 is written one edge later.
// Backpressure: in_ready drops for the WRITE_HI cycle.
// Optional macro WB_BYPASS_EN: forwards the value being written this cycle to the read ports.
module alu_writeback #(
  parameter int HI_REG = 15,
  parameter int NREGS  = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  in_op,
  input  logic [3:0]  in_dest,
  input  logic [15:0] in_out1,
  input  logic [15:0] in_out2,
  input  logic        in_overflow,
  input  logic [3:0]  rd_addr_a,
  input  logic [3:0]  rd_addr_b,
  output logic [15:0] rd_data_a,
  output logic [15:0] rd_data_b,
  output logic [2:0]  flags,
  output logic        busy
);

  typedef enum logic [0:0] {
    IDLE     = 1'b0,
    WRITE_HI = 1'b1
  } state_t;

  localparam logic [3:0] HI_ADDR = 4'(HI_REG);

  state_t      state_q, state_d;
  logic [15:0] regs_q [NREGS];
  logic [15:0] hold_q, hold_d;
  logic [2:0]  flags_q, flags_d;   // {overflow, negative, zero}

  logic        accept;
  logic        op_writes;          // ops 0-9 write out1 and update flags
  logic        op_two_cycle;       // ops 4/5 also produce out2
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [15:0] wr_data;

  assign in_ready     = (state_q == IDLE);
  assign busy         = (state_q == WRITE_HI);
  assign flags        = flags_q;
  assign accept       = in_valid & in_ready;
  assign op_writes    = (in_op <= 4'd9);
  assign op_two_cycle = (in_op == 4'd4) || (in_op == 4'd5);

  // Next-state, write port and flag update; defaults hold everything
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    flags_d = flags_q;
    wr_en   = 1'b0;
    wr_addr = in_dest;
    wr_data = in_out1;
    unique case (state_q)
      IDLE: begin
        if (accept && op_writes) begin
          // Index 0 is hardwired to zero, so its writes are dropped here
          wr_en      = (in_dest != 4'd0);
          wr_addr    = in_dest;
          wr_data    = in_out1;
          flags_d[0] = (in_out1 == 16'h0000);
          flags_d[1] = in_out1[15];
          if (in_op == 4'd0 || in_op == 4'd1) begin
            flags_d[2] = in_overflow;
          end
          if (op_two_cycle) begin
            hold_d  = in_out2;
            state_d = WRITE_HI;
          end
        end
      end
      WRITE_HI: begin
        // Second half of a mul/div: out2 lands in HI_REG, overriding any out1 there
        wr_en   = (HI_ADDR != 4'd0);
        wr_addr = HI_ADDR;
        wr_data = hold_q;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, hold register and flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      hold_q  <= 16'h0000;
      flags_q <= 3'b000;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      flags_q <= flags_d;
    end
  end

  // Register file; reset clears every entry so a reset mid-WRITE_HI leaves nothing behind
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= 16'h0000;
      end
    end else if (wr_en && (32'(wr_addr) < NREGS)) begin
      regs_q[wr_addr] <= wr_data;
    end
  end

  // Stored value of one register; index 0 and out-of-range indices read as zero
  function automatic logic [15:0] stored_rd(input logic [3:0] addr);
    logic [15:0] v;
    v = 16'h0000;
    if (addr != 4'd0 && (32'(addr) < NREGS)) begin
      v = regs_q[addr];
    end
    return v;
  endfunction

`ifdef WB_BYPASS_EN
  // Forward the value being written this cycle so a dependent read sees it immediately
  always_comb begin
    rd_data_a = stored_rd(rd_addr_a);
    rd_data_b = stored_rd(rd_addr_b);
    if (wr_en && (rd_addr_a == wr_addr)) begin
      rd_data_a = wr_data;
    end
    if (wr_en && (rd_addr_b == wr_addr)) begin
      rd_data_b = wr_data;
    end
  end
`else
  // Reads return the pre-edge contents; new data shows up the cycle after the write
  always_comb begin
    rd_data_a = stored_rd(rd_addr_a);
    rd_data_b = stored_rd(rd_addr_b);
  end
`endif

endmodule

// File: tb/tb_alu_writeback.sv
// Directed testbench for alu_writeback: reset state, single- and two-cycle writebacks,
// flag behaviour, register 0, NOP ops, reset during WRITE_HI and read forwarding.
module tb_alu_writeback;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_op;
  logic [3:0]  in_dest;
  logic [15:0] in_out1;
  logic [15:0] in_out2;
  logic        in_overflow;
  logic [3:0]  rd_addr_a;
  logic [3:0]  rd_addr_b;
  logic [15:0] rd_data_a;
  logic [15:0] rd_data_b;
  logic [2:0]  flags;
  logic        busy;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  alu_writeback dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_op       (in_op),
    .in_dest     (in_dest),
    .in_out1     (in_out1),
    .in_out2     (in_out2),
    .in_overflow (in_overflow),
    .rd_addr_a   (rd_addr_a),
    .rd_addr_b   (rd_addr_b),
    .rd_data_a   (rd_data_a),
    .rd_data_b   (rd_data_b),
    .flags       (flags),
    .busy        (busy)
  );

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%04h expected 0x%04h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one result; it is consumed at the next rising edge if in_ready is high
  task automatic put(input logic [3:0] op, input logic [3:0] dest, input logic [15:0] o1,
                     input logic [15:0] o2, input logic ov);
    in_valid    = 1'b1;
    in_op       = op;
    in_dest     = dest;
    in_out1     = o1;
    in_out2     = o2;
    in_overflow = ov;
  endtask

  task automatic idle_in();
    in_valid    = 1'b0;
    in_op       = 4'd15;
    in_dest     = 4'd0;
    in_out1     = 16'h0000;
    in_out2     = 16'h0000;
    in_overflow = 1'b0;
  endtask

  initial begin
    rst       = 1'b1;
    rd_addr_a = 4'd3;
    rd_addr_b = 4'd15;
    idle_in();
    #12;
    chk("rst_in_ready", 16'(in_ready), 16'h1);
    chk("rst_busy",     16'(busy),     16'h0);
    chk("rst_flags",    16'(flags),    16'h0);
    chk("rst_reg3",     rd_data_a,     16'h0000);
    chk("rst_reg15",    rd_data_b,     16'h0000);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // op 0 on the first edge after reset release
    put(4'd0, 4'd3, 16'h7FFF, 16'h0000, 1'b1);
    #1;
`ifdef WB_BYPASS_EN
    chk("op0_reg3_same_cycle", rd_data_a, 16'h7FFF);
`else
    chk("op0_reg3_same_cycle", rd_data_a, 16'h0000);
`endif
    tick();
    idle_in();
    chk("op0_reg3",  rd_data_a,  16'h7FFF);
    chk("op0_flags", 16'(flags), 16'h4);

    // op 4: out1 now, out2 into reg15 next cycle; a result offered during WRITE_HI is not taken
    rd_addr_a = 4'd2;
    rd_addr_b = 4'd15;
    put(4'd4, 4'd2, 16'h0010, 16'hFFFF, 1'b0);
    tick();
    put(4'd0, 4'd4, 16'h5555, 16'h0000, 1'b0);
    chk("op4_c1_reg2",     rd_data_a,         16'h0010);
    chk("op4_c1_in_ready", 16'(in_ready),     16'h0);
    chk("op4_c1_busy",     16'(busy),         16'h1);
    chk("op4_c1_flags",    16'(flags),        16'h4);
`ifdef WB_BYPASS_EN
    chk("op4_c1_reg15",    rd_data_b,         16'hFFFF);
`else
    chk("op4_c1_reg15",    rd_data_b,         16'h0000);
`endif
    tick();
    idle_in();
    rd_addr_a = 4'd4;
    #1;
    chk("op4_c2_reg15",    rd_data_b,     16'hFFFF);
    chk("op4_c2_in_ready", 16'(in_ready), 16'h1);
    chk("op4_c2_busy",     16'(busy),     16'h0);
    chk("op4_c2_reg4",     rd_data_a,     16'h0000);
    chk("op4_c2_flags",    16'(flags),    16'h4);

    // op 5 with dest == HI_REG: out1 for one cycle, then out2 wins
    rd_addr_a = 4'd15;
    put(4'd5, 4'd15, 16'h0003, 16'h0001, 1'b1);
    tick();
    idle_in();
    #1;
`ifdef WB_BYPASS_EN
    chk("op5_c1_reg15", rd_data_a, 16'h0001);
`else
    chk("op5_c1_reg15", rd_data_a, 16'h0003);
`endif
    tick();
    chk("op5_c2_reg15", rd_data_a,  16'h0001);
    chk("op5_flags",    16'(flags), 16'h4);

    // Register 0 stays zero; op 2 sets zero flag and keeps overflow
    rd_addr_a = 4'd0;
    put(4'd6, 4'd0, 16'h1234, 16'h0000, 1'b0);
    tick();
    put(4'd2, 4'd6, 16'h0000, 16'h0000, 1'b0);
    chk("reg0_after_write", rd_data_a, 16'h0000);
    tick();
    idle_in();
    chk("reg0_read",     rd_data_a,  16'h0000);
    chk("op2_zero_flag", 16'(flags), 16'h5);

    // Negative flag and overflow cleared by op 1
    rd_addr_a = 4'd7;
    put(4'd1, 4'd7, 16'h8000, 16'h0000, 1'b0);
    tick();
    idle_in();
    chk("op1_reg7",  rd_data_a,  16'h8000);
    chk("op1_flags", 16'(flags), 16'h2);

    // NOP op 12: nothing changes
    put(4'd12, 4'd7, 16'h0000, 16'hAAAA, 1'b1);
    tick();
    idle_in();
    chk("nop_reg7",     rd_data_a,     16'h8000);
    chk("nop_flags",    16'(flags),    16'h2);
    chk("nop_in_ready", 16'(in_ready), 16'h1);
    chk("nop_busy",     16'(busy),     16'h0);

    // Read of the register being written this cycle
    rd_addr_a = 4'd5;
    put(4'd1, 4'd5, 16'h00AA, 16'h0000, 1'b0);
    #1;
`ifdef WB_BYPASS_EN
    chk("rd5_same_cycle", rd_data_a, 16'h00AA);
`else
    chk("rd5_same_cycle", rd_data_a, 16'h0000);
`endif
    tick();
    idle_in();
    chk("rd5_next_cycle", rd_data_a,  16'h00AA);
    chk("op1_aa_flags",   16'(flags), 16'h0);

    // Second op 4 to a fresh register, both ports on the same register
    rd_addr_a = 4'd9;
    rd_addr_b = 4'd9;
    put(4'd4, 4'd9, 16'h0100, 16'h0BCD, 1'b0);
    tick();
    idle_in();
    chk("same_reg_a", rd_data_a, 16'h0100);
    chk("same_reg_b", rd_data_b, 16'h0100);
    tick();
    rd_addr_b = 4'd15;
    #1;
    chk("op4b_reg15", rd_data_b, 16'h0BCD);

    // Reset in the middle of WRITE_HI discards the pending out2
    rd_addr_a = 4'd8;
    rd_addr_b = 4'd15;
    put(4'd4, 4'd8, 16'h8011, 16'h4321, 1'b0);
    tick();
    idle_in();
    chk("pre_rst_busy", 16'(busy), 16'h1);
    rst = 1'b1;
    #1;
    chk("mid_rst_reg15",    rd_data_b,     16'h0000);
    chk("mid_rst_reg8",     rd_data_a,     16'h0000);
    chk("mid_rst_busy",     16'(busy),     16'h0);
    chk("mid_rst_in_ready", 16'(in_ready), 16'h1);
    chk("mid_rst_flags",    16'(flags),    16'h0);
    tick();
    rst = 1'b0;
    tick();
    chk("post_rst_reg15", rd_data_b,     16'h0000);
    chk("post_rst_busy",  16'(busy),     16'h0);
    chk("post_rst_flags", 16'(flags),    16'h0);

    // First accept right after reset release
    rd_addr_a = 4'd1;
    put(4'd3, 4'd1, 16'hFFFE, 16'h0000, 1'b1);
    tick();
    idle_in();
    chk("post_rst_reg1",   rd_data_a,  16'hFFFE);
    chk("post_rst_flags2", 16'(flags), 16'h2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
